// File: rtl/top_pin_scan_driver_if.sv
// Bit-serial stimulus/response link between the test host and top_pin_scan_driver.
interface top_pin_scan_driver_if;
  logic si_data;
  logic si_valid;
  logic si_ready;
  logic so_data;
  logic so_valid;
  logic so_ready;

  modport master (
    output si_data, si_valid, so_ready,
    input  si_ready, so_data, so_valid
  );

  modport slave (
    input  si_data, si_valid, so_ready,
    output si_ready, so_data, so_valid
  );
endinterface

// File: rtl/top_pin_scan_driver.sv
// Deserializes a stimulus frame onto top's input pins, waits a settle time,
// captures top's outputs and serializes the response back over the link.
module top_pin_scan_driver #(
  parameter int unsigned IN_W       = 4,
  parameter int unsigned OUT_W      = 3,
  parameter int unsigned SETTLE_CYC = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  top_pin_scan_driver_if.slave   lnk,
  output logic                   drive_in0,
  output logic                   drive_in1,
  output logic [1:0]             drive_bus_in,
  input  logic                   sense_out0,
  input  logic [1:0]             sense_bus_out,
  output logic                   busy,
  output logic                   frame_done
);

  localparam int unsigned MAXW = (IN_W > OUT_W) ? IN_W : OUT_W;
  localparam int unsigned CW   = $clog2(MAXW + 1);

  typedef enum logic [2:0] {
    IDLE,
    SHIFT_IN,
    APPLY,
    SETTLE,
    CAPTURE,
    SHIFT_OUT
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [CW-1:0]      r_cnt;
  logic [7:0]         r_scnt;
  logic [IN_W-1:0]    r_in_sr;
  logic [OUT_W-1:0]   r_out_sr;
  logic [IN_W-1:0]    r_drive;

  logic               w_si_ready;
  logic               w_so_valid;
  logic               w_so_data;
  logic               w_frame_done;
  logic               w_sel_bit;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Response bit currently addressed by the shared bit counter.
  always_comb begin
    w_sel_bit = 1'b0;
    for (int unsigned i = 0; i < OUT_W; i++) begin
      if (r_cnt == CW'(i)) w_sel_bit = r_out_sr[i];
    end
  end

  always_comb begin
    w_next       = r_state;
    w_si_ready   = 1'b0;
    w_so_valid   = 1'b0;
    w_so_data    = 1'b0;
    w_frame_done = 1'b0;
    case (r_state)
      IDLE: begin
        w_si_ready = 1'b1;
        if (lnk.si_valid) w_next = (IN_W == 1) ? APPLY : SHIFT_IN;
      end
      SHIFT_IN: begin
        w_si_ready = 1'b1;
        if (lnk.si_valid && (r_cnt == CW'(IN_W - 1))) w_next = APPLY;
      end
      APPLY:   w_next = SETTLE;
      SETTLE:  if (r_scnt == 8'd0) w_next = CAPTURE;
      CAPTURE: w_next = SHIFT_OUT;
      SHIFT_OUT: begin
        w_so_valid = 1'b1;
        w_so_data  = w_sel_bit;
        if (lnk.so_ready && (r_cnt == CW'(OUT_W - 1))) begin
          w_frame_done = 1'b1;
          w_next       = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt    <= '0;
      r_scnt   <= '0;
      r_in_sr  <= '0;
      r_out_sr <= '0;
      r_drive  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (lnk.si_valid) begin
            r_in_sr[0] <= lnk.si_data;
            r_cnt      <= CW'(1);
          end
        end
        SHIFT_IN: begin
          if (lnk.si_valid) begin
            for (int unsigned i = 0; i < IN_W; i++) begin
              if (r_cnt == CW'(i)) r_in_sr[i] <= lnk.si_data;
            end
            r_cnt <= r_cnt + CW'(1);
          end
        end
        APPLY: begin
          r_drive <= r_in_sr;
          r_scnt  <= 8'(SETTLE_CYC - 1);
        end
        SETTLE: begin
          if (r_scnt != 8'd0) r_scnt <= r_scnt - 8'd1;
        end
        CAPTURE: begin
          r_out_sr <= {sense_bus_out, sense_out0};
          r_cnt    <= '0;
        end
        SHIFT_OUT: begin
          if (lnk.so_ready) r_cnt <= r_cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

  assign lnk.si_ready = w_si_ready;
  assign lnk.so_valid = w_so_valid;
  assign lnk.so_data  = w_so_data;
  assign frame_done   = w_frame_done;
  assign busy         = (r_state != IDLE);
  assign drive_in0    = r_drive[0];
  assign drive_in1    = r_drive[1];
  assign drive_bus_in = r_drive[3:2];

endmodule

// File: tb/tb_top_pin_scan_driver.sv
// Directed bench: one driver with SETTLE_CYC=2 and one with SETTLE_CYC=1 share stimulus.
module tb_top_pin_scan_driver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       si_data, si_valid, so_ready;
  logic       sense_out0;
  logic [1:0] sense_bus_out;
  logic       sel;

  top_pin_scan_driver_if ifa ();
  top_pin_scan_driver_if ifb ();

  assign ifa.si_data  = si_data;
  assign ifa.si_valid = si_valid;
  assign ifa.so_ready = so_ready;
  assign ifb.si_data  = si_data;
  assign ifb.si_valid = si_valid;
  assign ifb.so_ready = so_ready;

  logic       a_in0, a_in1, a_busy, a_fd;
  logic [1:0] a_bus;
  logic       b_in0, b_in1, b_busy, b_fd;
  logic [1:0] b_bus;

  top_pin_scan_driver #(.IN_W(4), .OUT_W(3), .SETTLE_CYC(2)) u_a (
    .clk(clk), .reset(reset), .lnk(ifa.slave),
    .drive_in0(a_in0), .drive_in1(a_in1), .drive_bus_in(a_bus),
    .sense_out0(sense_out0), .sense_bus_out(sense_bus_out),
    .busy(a_busy), .frame_done(a_fd)
  );

  top_pin_scan_driver #(.IN_W(4), .OUT_W(3), .SETTLE_CYC(1)) u_b (
    .clk(clk), .reset(reset), .lnk(ifb.slave),
    .drive_in0(b_in0), .drive_in1(b_in1), .drive_bus_in(b_bus),
    .sense_out0(sense_out0), .sense_bus_out(sense_bus_out),
    .busy(b_busy), .frame_done(b_fd)
  );

  logic       o_in0, o_in1, o_busy, o_fd, o_si_ready, o_so_valid, o_so_data;
  logic [1:0] o_bus;
  assign o_in0      = sel ? b_in0 : a_in0;
  assign o_in1      = sel ? b_in1 : a_in1;
  assign o_bus      = sel ? b_bus : a_bus;
  assign o_busy     = sel ? b_busy : a_busy;
  assign o_fd       = sel ? b_fd : a_fd;
  assign o_si_ready = sel ? ifb.si_ready : ifa.si_ready;
  assign o_so_valid = sel ? ifb.so_valid : ifa.so_valid;
  assign o_so_data  = sel ? ifb.so_data : ifa.so_data;

  int n_checks = 0;
  int n_err    = 0;

  logic       p_in0, p_in1;
  logic [1:0] p_bus;

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk2(input string name, input logic [1:0] act, input logic [1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_prev(input string tag);
    chk1({tag, "_hold_in0"}, o_in0, p_in0);
    chk1({tag, "_hold_in1"}, o_in1, p_in1);
    chk2({tag, "_hold_bus"}, o_bus, p_bus);
  endtask

  // One full frame; returns right after the final response handshake cycle.
  task automatic run_frame(input logic [3:0] frame, input logic [2:0] sense,
                           input logic e_in0, input logic e_in1, input logic [1:0] e_bus,
                           input logic [2:0] e_bits, input int settle,
                           input int gap, input int bp_at);
    sense_out0    = sense[0];
    sense_bus_out = sense[2:1];
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      si_valid = 1'b1;
      si_data  = frame[i];
      so_ready = 1'b0;
      chk1("shift_si_ready", o_si_ready, 1'b1);
      chk1("shift_so_valid", o_so_valid, 1'b0);
      chk1("shift_busy", o_busy, logic'(i != 0));
      chk1("shift_frame_done", o_fd, 1'b0);
      chk_prev("shift");
      if (i < 3) begin
        for (int g = 0; g < gap; g++) begin
          @(negedge clk);
          si_valid = 1'b0;
          si_data  = ~si_data;
          chk1("gap_si_ready", o_si_ready, 1'b1);
          chk1("gap_busy", o_busy, 1'b1);
        end
      end
    end
    // APPLY: a stray valid bit here must be refused
    @(negedge clk);
    si_valid = 1'b1;
    si_data  = 1'b1;
    chk1("apply_si_ready", o_si_ready, 1'b0);
    chk1("apply_busy", o_busy, 1'b1);
    chk_prev("apply");
    @(negedge clk);
    si_valid = 1'b0;
    chk1("drive_in0", o_in0, e_in0);
    chk1("drive_in1", o_in1, e_in1);
    chk2("drive_bus_in", o_bus, e_bus);
    chk1("settle_si_ready", o_si_ready, 1'b0);
    chk1("settle_so_valid", o_so_valid, 1'b0);
    for (int k = 0; k < settle; k++) begin
      @(negedge clk);
      chk1("wait_so_valid", o_so_valid, 1'b0);
      chk1("wait_busy", o_busy, 1'b1);
    end
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      if (j == bp_at) begin
        for (int s = 0; s < 5; s++) begin
          so_ready = 1'b0;
          chk1("bp_so_valid", o_so_valid, 1'b1);
          chk1("bp_so_data", o_so_data, e_bits[j]);
          chk1("bp_frame_done", o_fd, 1'b0);
          @(negedge clk);
        end
      end
      so_ready = 1'b1;
      chk1("so_valid", o_so_valid, 1'b1);
      chk1("so_data", o_so_data, e_bits[j]);
      chk1("frame_done", o_fd, logic'(j == 2));
    end
    p_in0 = e_in0;
    p_in1 = e_in1;
    p_bus = e_bus;
  endtask

  task automatic idle_check();
    @(negedge clk);
    so_ready = 1'b0;
    si_valid = 1'b0;
    chk1("idle_busy", o_busy, 1'b0);
    chk1("idle_so_valid", o_so_valid, 1'b0);
    chk1("idle_si_ready", o_si_ready, 1'b1);
    chk1("idle_frame_done", o_fd, 1'b0);
    chk_prev("idle");
  endtask

  typedef struct {
    logic [3:0] frame;
    logic [2:0] sense;
    logic       e_in0;
    logic       e_in1;
    logic [1:0] e_bus;
    logic [2:0] e_bits;
  } vec_t;

  vec_t vecs [5];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{frame: 4'b1011, sense: 3'b101, e_in0: 1'b1, e_in1: 1'b1, e_bus: 2'b10, e_bits: 3'b101};
    vecs[1] = '{frame: 4'b0100, sense: 3'b010, e_in0: 1'b0, e_in1: 1'b0, e_bus: 2'b01, e_bits: 3'b010};
    vecs[2] = '{frame: 4'b1111, sense: 3'b111, e_in0: 1'b1, e_in1: 1'b1, e_bus: 2'b11, e_bits: 3'b111};
    vecs[3] = '{frame: 4'b0110, sense: 3'b011, e_in0: 1'b0, e_in1: 1'b1, e_bus: 2'b01, e_bits: 3'b011};
    vecs[4] = '{frame: 4'b1000, sense: 3'b100, e_in0: 1'b0, e_in1: 1'b0, e_bus: 2'b10, e_bits: 3'b100};

    reset = 1'b1; si_data = 1'b0; si_valid = 1'b0; so_ready = 1'b0;
    sense_out0 = 1'b0; sense_bus_out = 2'b00; sel = 1'b0;
    p_in0 = 1'b0; p_in1 = 1'b0; p_bus = 2'b00;

    repeat (3) @(negedge clk);
    reset = 1'b0;
    idle_check();
    chk1("rst_so_data", o_so_data, 1'b0);

    for (int v = 0; v < 5; v++) begin
      run_frame(vecs[v].frame, vecs[v].sense, vecs[v].e_in0, vecs[v].e_in1,
                vecs[v].e_bus, vecs[v].e_bits, 2, 0, -1);
      idle_check();
    end

    // Backpressure on the middle response bit
    run_frame(vecs[0].frame, vecs[0].sense, vecs[0].e_in0, vecs[0].e_in1,
              vecs[0].e_bus, vecs[0].e_bits, 2, 0, 1);
    idle_check();

    // Two-cycle si_valid gaps between accepted bits
    run_frame(vecs[3].frame, vecs[3].sense, vecs[3].e_in0, vecs[3].e_in1,
              vecs[3].e_bus, vecs[3].e_bits, 2, 2, -1);
    idle_check();

    // Reset asserted while settling
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      si_valid = 1'b1;
      si_data  = vecs[0].frame[i];
    end
    @(negedge clk);
    si_valid = 1'b0;
    @(negedge clk);
    chk1("mid_drive_in0", o_in0, 1'b1);
    chk2("mid_drive_bus", o_bus, 2'b10);
    reset = 1'b1;
    @(negedge clk);
    chk1("rst_mid_in0", o_in0, 1'b0);
    chk1("rst_mid_in1", o_in1, 1'b0);
    chk2("rst_mid_bus", o_bus, 2'b00);
    chk1("rst_mid_busy", o_busy, 1'b0);
    chk1("rst_mid_so_valid", o_so_valid, 1'b0);
    reset = 1'b0;
    p_in0 = 1'b0; p_in1 = 1'b0; p_bus = 2'b00;
    run_frame(vecs[1].frame, vecs[1].sense, vecs[1].e_in0, vecs[1].e_in1,
              vecs[1].e_bus, vecs[1].e_bits, 2, 0, -1);
    idle_check();

    // Back-to-back frames on the SETTLE_CYC=1 instance
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    sel   = 1'b1;
    p_in0 = 1'b0; p_in1 = 1'b0; p_bus = 2'b00;
    run_frame(vecs[2].frame, vecs[2].sense, vecs[2].e_in0, vecs[2].e_in1,
              vecs[2].e_bus, vecs[2].e_bits, 1, 0, -1);
    run_frame(vecs[4].frame, vecs[4].sense, vecs[4].e_in0, vecs[4].e_in1,
              vecs[4].e_bus, vecs[4].e_bits, 1, 0, -1);
    idle_check();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
